// File: rtl/adbg_run_ctrl.sv
// Debug run control: halts, resumes and single-steps a set of cores on host command.
// Optional STEP support is built only when ADBG_RUNCTRL_STEP_EN is defined.
module adbg_run_ctrl #(
  parameter int NB_CORES = 4,
  parameter int TIMEOUT  = 255
) (
  input  logic                cpu_clk_i,
  input  logic                cpu_rst_i,
  input  logic                cmd_valid_i,
  output logic                cmd_ready_o,
  input  logic [1:0]          cmd_op_i,
  input  logic [NB_CORES-1:0] cmd_mask_i,
  input  logic [NB_CORES-1:0] bp_i,
  input  logic [NB_CORES-1:0] halted_i,
  output logic [NB_CORES-1:0] stall_o,
  output logic [NB_CORES-1:0] bp_seen_o,
  output logic                done_o,
  output logic                err_o
);

  localparam int TW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TIMER_INIT = TW'(TIMEOUT);

  localparam logic [1:0] OP_NOP    = 2'b00;
  localparam logic [1:0] OP_HALT   = 2'b01;
  localparam logic [1:0] OP_RESUME = 2'b10;
  localparam logic [1:0] OP_STEP   = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    HALT_WAIT,
`ifdef ADBG_RUNCTRL_STEP_EN
    STEP_RUN,
    STEP_WAIT,
`endif
    DONE
  } state_t;

  state_t              state_q, state_d;
  logic [NB_CORES-1:0] mask_q, mask_d;
  logic [NB_CORES-1:0] stall_q, stall_d;
  logic [NB_CORES-1:0] bp_seen_q, bp_seen_d;
  logic [TW-1:0]       timer_q, timer_d;
  logic                err_lat_q, err_lat_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic                accept;

  assign cmd_ready_o = (state_q == IDLE);
  assign accept      = cmd_valid_i & cmd_ready_o;

  always_comb begin
    state_d   = state_q;
    mask_d    = mask_q;
    stall_d   = stall_q;
    bp_seen_d = bp_seen_q;
    timer_d   = timer_q;
    err_lat_d = err_lat_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          mask_d    = cmd_mask_i;
          err_lat_d = 1'b0;
          case (cmd_op_i)
            OP_NOP: state_d = DONE;
            OP_RESUME: begin
              stall_d   = stall_q & ~cmd_mask_i;
              bp_seen_d = bp_seen_q & ~cmd_mask_i;
              state_d   = DONE;
            end
            OP_HALT: begin
              stall_d = stall_q | cmd_mask_i;
              timer_d = TIMER_INIT;
              state_d = HALT_WAIT;
            end
            OP_STEP: begin
`ifdef ADBG_RUNCTRL_STEP_EN
              stall_d   = stall_q & ~cmd_mask_i;
              bp_seen_d = bp_seen_q & ~cmd_mask_i;
              state_d   = STEP_RUN;
`else
              err_lat_d = 1'b1;
              state_d   = DONE;
`endif
            end
            default: state_d = DONE;
          endcase
        end
      end

`ifdef ADBG_RUNCTRL_STEP_EN
      STEP_RUN: begin
        stall_d = stall_q | mask_q;
        timer_d = TIMER_INIT;
        state_d = STEP_WAIT;
      end
`endif

`ifdef ADBG_RUNCTRL_STEP_EN
      HALT_WAIT, STEP_WAIT: begin
`else
      HALT_WAIT: begin
`endif
        if ((halted_i & mask_q) == mask_q) begin
          state_d = DONE;
        end else if (timer_q == '0) begin
          err_lat_d = 1'b1;
          state_d   = DONE;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end

      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // A breakpoint always wins over a clear issued in the same cycle.
    stall_d   = stall_d | bp_i;
    bp_seen_d = bp_seen_d | bp_i;

    done_d = (state_q == DONE);
    err_d  = (state_q == DONE) && err_lat_q;
  end

  always_ff @(posedge cpu_clk_i) begin
    if (cpu_rst_i) begin
      state_q   <= IDLE;
      mask_q    <= '0;
      stall_q   <= '0;
      bp_seen_q <= '0;
      timer_q   <= '0;
      err_lat_q <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      mask_q    <= mask_d;
      stall_q   <= stall_d;
      bp_seen_q <= bp_seen_d;
      timer_q   <= timer_d;
      err_lat_q <= err_lat_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign stall_o   = stall_q;
  assign bp_seen_o = bp_seen_q;
  assign done_o    = done_q;
  assign err_o     = err_q;

endmodule

// File: tb/tb_adbg_run_ctrl.sv
// Directed bench for adbg_run_ctrl: a per-cycle vector table plus multi-cycle sequences.
module tb_adbg_run_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       vld;
  logic       rdy;
  logic [1:0] op;
  logic [3:0] mask, bp, hlt;
  logic [3:0] stall, seen;
  logic       done, err;

  int checks   = 0;
  int failures = 0;

  localparam logic [1:0] NOP = 2'b00, HALT = 2'b01, RES = 2'b10, STEP = 2'b11;

  adbg_run_ctrl #(.NB_CORES(4), .TIMEOUT(255)) dut (
    .cpu_clk_i   (clk),
    .cpu_rst_i   (rst),
    .cmd_valid_i (vld),
    .cmd_ready_o (rdy),
    .cmd_op_i    (op),
    .cmd_mask_i  (mask),
    .bp_i        (bp),
    .halted_i    (hlt),
    .stall_o     (stall),
    .bp_seen_o   (seen),
    .done_o      (done),
    .err_o       (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       vld;
    logic [1:0] op;
    logic [3:0] mask;
    logic [3:0] bp;
    logic [3:0] hlt;
    logic       rdy;
    logic [3:0] stall;
    logic [3:0] seen;
    logic       done;
    logic       err;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic r, input logic v, input logic [1:0] o, input logic [3:0] m,
                     input logic [3:0] b, input logic [3:0] h, input logic ry,
                     input logic [3:0] st, input logic [3:0] sn, input logic d, input logic e);
    vec_t x;
    x.rst = r; x.vld = v; x.op = o; x.mask = m; x.bp = b; x.hlt = h;
    x.rdy = ry; x.stall = st; x.seen = sn; x.done = d; x.err = e;
    tbl.push_back(x);
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    rst = 1'b0; vld = 1'b0; op = NOP; mask = '0; bp = '0; hlt = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  dcyc;
    int  derr;
    logic any_done;

    idle_inputs();

    //   rst vld op    mask  bp    hlt  | rdy stall seen done err
    add(1, 0, NOP,  4'h0, 4'h0, 4'h0,  1, 4'h0, 4'h0, 0, 0);
    add(0, 1, HALT, 4'h5, 4'h0, 4'h0,  0, 4'h5, 4'h0, 0, 0);
    add(0, 0, HALT, 4'h5, 4'h0, 4'h0,  0, 4'h5, 4'h0, 0, 0);
    add(0, 0, NOP,  4'h0, 4'h0, 4'h5,  0, 4'h5, 4'h0, 0, 0);
    add(0, 0, NOP,  4'h0, 4'h0, 4'h5,  1, 4'h5, 4'h0, 1, 0);
    add(0, 0, NOP,  4'h0, 4'h0, 4'h0,  1, 4'h5, 4'h0, 0, 0);
    add(0, 1, RES,  4'h1, 4'h1, 4'h0,  0, 4'h5, 4'h1, 0, 0);
    add(0, 0, NOP,  4'h0, 4'h0, 4'h0,  1, 4'h5, 4'h1, 1, 0);
    add(0, 1, RES,  4'h5, 4'h0, 4'h0,  0, 4'h0, 4'h0, 0, 0);
    add(0, 0, NOP,  4'h0, 4'h0, 4'h0,  1, 4'h0, 4'h0, 1, 0);
    add(0, 1, NOP,  4'hF, 4'h0, 4'h0,  0, 4'h0, 4'h0, 0, 0);
    add(0, 1, NOP,  4'hF, 4'h0, 4'h0,  1, 4'h0, 4'h0, 1, 0);
    add(0, 0, NOP,  4'h0, 4'h0, 4'h0,  1, 4'h0, 4'h0, 0, 0);
    add(0, 1, HALT, 4'h0, 4'h0, 4'h0,  0, 4'h0, 4'h0, 0, 0);
    add(0, 0, NOP,  4'h0, 4'h0, 4'h0,  0, 4'h0, 4'h0, 0, 0);
    add(0, 0, NOP,  4'h0, 4'h0, 4'h0,  1, 4'h0, 4'h0, 1, 0);
    add(0, 0, NOP,  4'h0, 4'h2, 4'h0,  1, 4'h2, 4'h2, 0, 0);
    add(0, 0, NOP,  4'h0, 4'h0, 4'h0,  1, 4'h2, 4'h2, 0, 0);
    add(0, 1, RES,  4'h2, 4'h0, 4'h0,  0, 4'h0, 4'h0, 0, 0);
    add(0, 0, NOP,  4'h0, 4'h0, 4'h0,  1, 4'h0, 4'h0, 1, 0);
    add(0, 1, HALT, 4'h8, 4'h0, 4'h0,  0, 4'h8, 4'h0, 0, 0);
    add(0, 0, NOP,  4'h1, 4'h0, 4'h1,  0, 4'h8, 4'h0, 0, 0);
    add(0, 0, NOP,  4'h0, 4'h0, 4'h8,  0, 4'h8, 4'h0, 0, 0);
    add(0, 0, NOP,  4'h0, 4'h0, 4'h8,  1, 4'h8, 4'h0, 1, 0);

    foreach (tbl[i]) begin
      rst = tbl[i].rst; vld = tbl[i].vld; op = tbl[i].op;
      mask = tbl[i].mask; bp = tbl[i].bp; hlt = tbl[i].hlt;
      tick();
      chk($sformatf("v%0d_rdy", i),   int'(rdy),   int'(tbl[i].rdy));
      chk($sformatf("v%0d_stall", i), int'(stall), int'(tbl[i].stall));
      chk($sformatf("v%0d_seen", i),  int'(seen),  int'(tbl[i].seen));
      chk($sformatf("v%0d_done", i),  int'(done),  int'(tbl[i].done));
      chk($sformatf("v%0d_err", i),   int'(err),   int'(tbl[i].err));
    end

    // Halt that never gets acknowledged runs the full timeout.
    do_reset();
    vld = 1'b1; op = HALT; mask = 4'h2;
    tick();
    idle_inputs();
    dcyc = -1;
    derr = -1;
    for (int c = 1; c <= 300; c++) begin
      if (c > 1) tick();
      if (done && dcyc < 0) begin
        dcyc = c;
        derr = int'(err);
        break;
      end
    end
    chk("timeout_cycle", dcyc, 258);
    chk("timeout_err", derr, 1);
    chk("timeout_stall1", int'(stall[1]), 1);

    // Reset in the middle of a halt wait abandons the command.
    do_reset();
    vld = 1'b1; op = HALT; mask = 4'hF;
    tick();
    idle_inputs();
    bp = 4'h4;
    tick();
    bp = 4'h0;
    tick();
    chk("rstmid_seen_pre", int'(seen), 4);
    chk("rstmid_stall_pre", int'(stall), 15);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rstmid_stall", int'(stall), 0);
    chk("rstmid_seen", int'(seen), 0);
    chk("rstmid_rdy", int'(rdy), 1);
    any_done = done;
    for (int c = 0; c < 4; c++) begin
      tick();
      any_done = any_done | done;
    end
    chk("rstmid_no_done", int'(any_done), 0);

`ifdef ADBG_RUNCTRL_STEP_EN
    do_reset();
    vld = 1'b1; op = HALT; mask = 4'hF; hlt = 4'hF;
    tick();
    vld = 1'b0;
    tick();
    tick();
    hlt = 4'h0; bp = 4'h8;
    tick();
    bp = 4'h0;
    chk("step_pre_stall", int'(stall), 15);
    chk("step_pre_seen", int'(seen), 8);
    vld = 1'b1; op = STEP; mask = 4'h8;
    tick();
    vld = 1'b0; mask = 4'h0;
    chk("step_run_stall", int'(stall), 7);
    chk("step_run_seen", int'(seen), 0);
    tick();
    chk("step_wait_stall", int'(stall), 15);
    tick();
    chk("step_wait2_stall", int'(stall), 15);
    chk("step_wait2_done", int'(done), 0);
    hlt = 4'h8;
    tick();
    chk("step_fin_done0", int'(done), 0);
    tick();
    chk("step_done", int'(done), 1);
    chk("step_err", int'(err), 0);
    chk("step_final_stall", int'(stall), 15);
`else
    do_reset();
    bp = 4'h4;
    tick();
    bp = 4'h0;
    vld = 1'b1; op = STEP; mask = 4'h1;
    tick();
    vld = 1'b0;
    chk("nostep_acc_rdy", int'(rdy), 0);
    chk("nostep_acc_stall", int'(stall), 4);
    chk("nostep_acc_done", int'(done), 0);
    tick();
    chk("nostep_done", int'(done), 1);
    chk("nostep_err", int'(err), 1);
    chk("nostep_stall", int'(stall), 4);
    chk("nostep_seen", int'(seen), 4);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
